// File: rtl/gppcu_lane.sv
// gppcu_lane: one SIMD thread lane (decode operands, execute, writeback).
// Optional GPPCU_LANE_FWD_EN: forward committing writeback data into decode.
module gppcu_lane #(
   parameter  int DATA_BITS      = 32,
   parameter  int REG_COUNT      = 32,
   parameter  int LMEM_WORD_BITS = 10,
   localparam int RSEL           = $clog2(REG_COUNT)
) (
   input  logic                      iACLK,
   input  logic                      iRST,
   input  logic                      iDEC_VALID,
   input  logic [RSEL-1:0]           iDEC_RA,
   input  logic [RSEL-1:0]           iDEC_RB,
   input  logic [1:0]                iDEC_BSEL,
   input  logic [DATA_BITS-1:0]      iDEC_IMM,
   input  logic [DATA_BITS-1:0]      iGMEMDATA,
   input  logic                      iEX_VALID,
   input  logic [3:0]                iEX_OP,
   input  logic [3:0]                iEX_COND,
   input  logic                      iEX_SETS,
   input  logic                      iEX_LMWR,
   input  logic                      iEX_MC,
   input  logic                      iWB_VALID,
   input  logic [RSEL-1:0]           iWB_RD,
   input  logic                      iWB_REGWR,
   input  logic                      iWB_LMRD,
   input  logic                      iWB_MC,
   input  logic                      iLMEMSEL,
   input  logic                      iLMEMWREN,
   input  logic [LMEM_WORD_BITS-1:0] iLMEMADDR,
   input  logic [DATA_BITS-1:0]      iLMEMWDATA,
   output logic [DATA_BITS-1:0]      oLMEMRDATA,
   output logic [3:0]                oSREG,
   output logic                      oBUSY
);

   localparam int MSB  = DATA_BITS - 1;
   localparam int CNTW = $clog2(DATA_BITS);
   localparam logic [CNTW-1:0] LAST = CNTW'(DATA_BITS - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} mul_state_t;

   typedef struct packed {
      logic                 ok;
      logic [DATA_BITS-1:0] alu;
      logic [DATA_BITS-1:0] prod;
      logic [DATA_BITS-1:0] ld;
   } wb_t;

   logic [DATA_BITS-1:0] rf [REG_COUNT];
   logic [DATA_BITS-1:0] lm [2**LMEM_WORD_BITS];

   logic [DATA_BITS-1:0] op_a, op_b;
   logic [DATA_BITS-1:0] rf_a, rf_b, dec_b;
   wb_t                  wb;
   logic [DATA_BITS-1:0] wb_d;
   logic                 rf_we;
   logic [3:0]           sreg;
   logic                 sv, sc, sn, sz;
   logic                 cond_ok, ok, mc_go, busy;
   logic [DATA_BITS-1:0] alu_y, ex_res;
   logic                 alu_c, alu_v;
   mul_state_t           state, state_nxt;
   logic [DATA_BITS-1:0] mcand, mplr, acc;
   logic [CNTW-1:0]      cnt;
   logic [LMEM_WORD_BITS-1:0] lm_addr;
   logic                 lm_we, host_we;
   logic [DATA_BITS-1:0] host_q;
   logic                 unused_dec_valid;

   assign unused_dec_valid = iDEC_VALID;

   assign rf_we = iWB_VALID & iWB_REGWR & wb.ok & ~busy;
   assign wb_d  = iWB_LMRD ? wb.ld : (iWB_MC ? wb.prod : wb.alu);

`ifdef GPPCU_LANE_FWD_EN
   assign rf_a = (rf_we && iWB_RD == iDEC_RA) ? wb_d : rf[iDEC_RA];
   assign rf_b = (rf_we && iWB_RD == iDEC_RB) ? wb_d : rf[iDEC_RB];
`else
   assign rf_a = rf[iDEC_RA];
   assign rf_b = rf[iDEC_RB];
`endif

   always_comb begin
      dec_b = iGMEMDATA;
      unique case (iDEC_BSEL)
         2'd0:    dec_b = rf_b + iDEC_IMM;
         2'd1:    dec_b = iDEC_IMM;
         2'd2:    dec_b = rf_b;
         default: dec_b = iGMEMDATA;
      endcase
   end

   assign {sv, sc, sn, sz} = sreg;

   always_comb begin
      cond_ok = 1'b0;
      unique case (iEX_COND)
         4'd0:    cond_ok = 1'b1;
         4'd1:    cond_ok = sz;
         4'd2:    cond_ok = ~sz;
         4'd3:    cond_ok = sc;
         4'd4:    cond_ok = ~sc;
         4'd5:    cond_ok = sn;
         4'd6:    cond_ok = ~sn;
         4'd7:    cond_ok = sv;
         4'd8:    cond_ok = ~sv;
         default: cond_ok = 1'b0;
      endcase
   end

   assign ok    = iEX_VALID & cond_ok;
   assign mc_go = ok & iEX_MC;
   assign busy  = mc_go & (state != S_DONE);
   assign oBUSY = busy;

   // C and V default to the held flags so only the arithmetic ops touch them
   always_comb begin
      alu_y = op_b;
      alu_c = sc;
      alu_v = sv;
      unique case (iEX_OP)
         4'd0: begin
            {alu_c, alu_y} = {1'b0, op_a} + {1'b0, op_b};
            alu_v = (op_a[MSB] == op_b[MSB]) & (alu_y[MSB] != op_a[MSB]);
         end
         4'd1: begin
            {alu_c, alu_y} = {1'b0, op_a} + {1'b0, op_b}
                           + {{DATA_BITS{1'b0}}, sc};
            alu_v = (op_a[MSB] == op_b[MSB]) & (alu_y[MSB] != op_a[MSB]);
         end
         4'd2: begin
            {alu_c, alu_y} = {1'b0, op_a} + {1'b0, ~op_b}
                           + {{DATA_BITS{1'b0}}, 1'b1};
            alu_v = (op_a[MSB] != op_b[MSB]) & (alu_y[MSB] != op_a[MSB]);
         end
         4'd3:    alu_y = op_a & op_b;
         4'd4:    alu_y = op_a | op_b;
         4'd5:    alu_y = op_a ^ op_b;
         4'd6:    alu_y = op_a << op_b[4:0];
         4'd7:    alu_y = op_a >> op_b[4:0];
         default: alu_y = op_b;
      endcase
   end

   assign ex_res = iEX_MC ? acc : alu_y;

   always_ff @(posedge iACLK) begin
      if (iRST) begin
         sreg <= '0;
      end else if (ok & iEX_SETS & ~busy) begin
         sreg[1] <= ex_res[MSB];
         sreg[0] <= (ex_res == '0);
         if (!iEX_MC) sreg[3:2] <= {alu_v, alu_c};
      end
   end
   assign oSREG = sreg;

   always_ff @(posedge iACLK) begin
      if (iRST) begin
         op_a <= '0;
         op_b <= '0;
         wb   <= '0;
      end else begin
         wb.ld <= lm[lm_addr];
         if (!busy) begin
            op_a   <= rf_a;
            op_b   <= dec_b;
            wb.ok  <= ok;
            wb.alu <= alu_y;
            if (state == S_DONE) wb.prod <= acc;
         end
      end
   end

   always_ff @(posedge iACLK) begin
      if (rf_we) rf[iWB_RD] <= wb_d;
   end

   always_ff @(posedge iACLK) begin
      if (iRST) state <= S_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE: if (mc_go) state_nxt = S_RUN;
         S_RUN: begin
            if (!mc_go)           state_nxt = S_IDLE;
            else if (cnt == LAST) state_nxt = S_DONE;
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Shift-add: operands latch while idle, one bit per RUN cycle
   always_ff @(posedge iACLK) begin
      if (iRST) begin
         mcand <= '0;
         mplr  <= '0;
         acc   <= '0;
         cnt   <= '0;
      end else if (state == S_RUN) begin
         if (mplr[0]) acc <= acc + mcand;
         mcand <= mcand << 1;
         mplr  <= mplr >> 1;
         cnt   <= cnt + 1'b1;
      end else if (state == S_IDLE) begin
         mcand <= op_a;
         mplr  <= op_b;
         acc   <= '0;
         cnt   <= '0;
      end
   end

   assign lm_addr = op_b[LMEM_WORD_BITS-1:0];
   assign lm_we   = ok & iEX_LMWR & ~busy;
   assign host_we = iLMEMSEL & iLMEMWREN
                  & ~(lm_we & (iLMEMADDR == lm_addr));

   always_ff @(posedge iACLK) begin
      if (lm_we)   lm[lm_addr]   <= op_a;
      if (host_we) lm[iLMEMADDR] <= iLMEMWDATA;
   end

   always_ff @(posedge iACLK) begin
      if (iRST)          host_q <= '0;
      else if (iLMEMSEL) host_q <= lm[iLMEMADDR];
   end
   assign oLMEMRDATA = host_q;

endmodule

// File: tb/tb_gppcu_lane.sv
// tb_gppcu_lane: random instruction stream vs an architectural lane model.
// Directed cases cover reset, flags, multiply, conditions, collisions, forwarding.
module tb_gppcu_lane;

   logic        iACLK;
   logic        iRST;
   logic        iDEC_VALID;
   logic [4:0]  iDEC_RA, iDEC_RB;
   logic [1:0]  iDEC_BSEL;
   logic [31:0] iDEC_IMM, iGMEMDATA;
   logic        iEX_VALID;
   logic [3:0]  iEX_OP, iEX_COND;
   logic        iEX_SETS, iEX_LMWR, iEX_MC;
   logic        iWB_VALID;
   logic [4:0]  iWB_RD;
   logic        iWB_REGWR, iWB_LMRD, iWB_MC;
   logic        iLMEMSEL, iLMEMWREN;
   logic [9:0]  iLMEMADDR;
   logic [31:0] iLMEMWDATA, oLMEMRDATA;
   logic [3:0]  oSREG;
   logic        oBUSY;

   gppcu_lane dut (
      .iACLK(iACLK), .iRST(iRST),
      .iDEC_VALID(iDEC_VALID), .iDEC_RA(iDEC_RA), .iDEC_RB(iDEC_RB),
      .iDEC_BSEL(iDEC_BSEL), .iDEC_IMM(iDEC_IMM), .iGMEMDATA(iGMEMDATA),
      .iEX_VALID(iEX_VALID), .iEX_OP(iEX_OP), .iEX_COND(iEX_COND),
      .iEX_SETS(iEX_SETS), .iEX_LMWR(iEX_LMWR), .iEX_MC(iEX_MC),
      .iWB_VALID(iWB_VALID), .iWB_RD(iWB_RD), .iWB_REGWR(iWB_REGWR),
      .iWB_LMRD(iWB_LMRD), .iWB_MC(iWB_MC),
      .iLMEMSEL(iLMEMSEL), .iLMEMWREN(iLMEMWREN), .iLMEMADDR(iLMEMADDR),
      .iLMEMWDATA(iLMEMWDATA), .oLMEMRDATA(oLMEMRDATA),
      .oSREG(oSREG), .oBUSY(oBUSY)
   );

   initial iACLK = 1'b0;
   always #5 iACLK = ~iACLK;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   typedef struct {
      int          ra, rb, bsel, op, cond, rd;
      logic [31:0] imm, gm;
      bit          sets, lmwr, mc, regwr, lmrd;
   } ins_t;

   int          n_vec = 0;
   int          n_bad = 0;
   logic [31:0] rf_m  [8];
   logic [31:0] mem_m [1024];
   logic [3:0]  sreg_m = 4'h0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic bit ovf(input longint s);
      return (s > 64'sd2147483647) || (s < -64'sd2147483648);
   endfunction

   function automatic ins_t mk(input int ra, input int bsel,
                               input logic [31:0] imm, input int op);
      ins_t in;
      in.ra = ra; in.rb = 1; in.bsel = bsel; in.imm = imm; in.gm = 0;
      in.op = op; in.cond = 0; in.rd = 1;
      in.sets = 0; in.lmwr = 0; in.mc = 0; in.regwr = 0; in.lmrd = 0;
      return in;
   endfunction

   function automatic ins_t rand_ins();
      ins_t in;
      int   k = $urandom_range(0, 9);
      in = mk($urandom_range(1, 7), $urandom_range(0, 3), $urandom,
              $urandom_range(0, 15));
      in.rb    = $urandom_range(1, 7);
      in.gm    = $urandom;
      in.cond  = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(0, 15);
      in.sets  = 1'($urandom_range(0, 1));
      in.rd    = $urandom_range(1, 7);
      in.regwr = 1;
      if (k == 7) begin
         in.lmwr = 1; in.regwr = 0;
      end else if (k == 8) begin
         in.lmrd = 1; in.bsel = 1;
         in.imm = ($urandom & 32'hFFFF_FC00) | $urandom_range(0, 15);
      end else if (k == 9) begin
         in.mc = 1;
      end
      return in;
   endfunction

   // Model first, then walk the instruction through D, E (+stall), W.
   task automatic exec(input ins_t in);
      logic [31:0] a, b, y, ld;
      logic [63:0] u;
      logic        v, c, n, z, nv, nc, ok;
      longint      sa, sb, s;
      int          nb, exp_nb;
      {v, c, n, z} = sreg_m;
      a = rf_m[in.ra];
      case (in.bsel)
         0:       b = rf_m[in.rb] + in.imm;
         1:       b = in.imm;
         2:       b = rf_m[in.rb];
         default: b = in.gm;
      endcase
      case (in.cond)
         0: ok = 1; 1: ok = z; 2: ok = !z; 3: ok = c; 4: ok = !c;
         5: ok = n; 6: ok = !n; 7: ok = v; 8: ok = !v;
         default: ok = 0;
      endcase
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      nc = c; nv = v; y = b;
      case (in.op)
         0: begin u = 64'(a) + 64'(b); y = u[31:0]; nc = u[32];
                  s = sa + sb; nv = ovf(s); end
         1: begin u = 64'(a) + 64'(b) + 64'(c); y = u[31:0]; nc = u[32];
                  s = sa + sb + longint'(c); nv = ovf(s); end
         2: begin y = a - b; nc = (a >= b); s = sa - sb; nv = ovf(s); end
         3: y = a & b;
         4: y = a | b;
         5: y = a ^ b;
         6: y = a << b[4:0];
         7: y = a >> b[4:0];
         default: y = b;
      endcase
      if (in.mc) begin
         u = 64'(a) * 64'(b);
         y = u[31:0];
      end
      exp_nb = (ok && in.mc) ? 33 : 0;
      ld = mem_m[b[9:0]];
      if (ok && in.sets)
         sreg_m = in.mc ? {v, c, y[31], y == 0} : {nv, nc, y[31], y == 0};
      if (ok && in.lmwr)  mem_m[b[9:0]] = a;
      if (ok && in.regwr) rf_m[in.rd] = in.lmrd ? ld : y;

      iDEC_VALID = 1; iDEC_RA = 5'(in.ra); iDEC_RB = 5'(in.rb);
      iDEC_BSEL = 2'(in.bsel); iDEC_IMM = in.imm; iGMEMDATA = in.gm;
      @(posedge iACLK); #1;
      iDEC_VALID = 0;
      iEX_VALID = 1; iEX_OP = 4'(in.op); iEX_COND = 4'(in.cond);
      iEX_SETS = in.sets; iEX_LMWR = in.lmwr; iEX_MC = in.mc;
      #1;
      nb = 0;
      while (oBUSY && nb < 100) begin
         nb++;
         @(posedge iACLK); #1;
      end
      check("busy_cycles", 32'(nb), 32'(exp_nb));
      @(posedge iACLK); #1;
      iEX_VALID = 0; iEX_SETS = 0; iEX_LMWR = 0; iEX_MC = 0;
      iWB_VALID = 1; iWB_RD = 5'(in.rd); iWB_REGWR = in.regwr;
      iWB_LMRD = in.lmrd; iWB_MC = in.mc;
      @(posedge iACLK); #1;
      iWB_VALID = 0; iWB_REGWR = 0; iWB_LMRD = 0; iWB_MC = 0;
      check("sreg", 32'(oSREG), 32'(sreg_m));
   endtask

   task automatic host_wr(input logic [9:0] a, input logic [31:0] d);
      iLMEMSEL = 1; iLMEMWREN = 1; iLMEMADDR = a; iLMEMWDATA = d;
      @(posedge iACLK); #1;
      iLMEMSEL = 0; iLMEMWREN = 0;
      mem_m[a] = d;
   endtask

   task automatic host_rd(input logic [9:0] a, output logic [31:0] v);
      iLMEMSEL = 1; iLMEMWREN = 0; iLMEMADDR = a;
      @(posedge iACLK); #1;
      iLMEMSEL = 0;
      v = oLMEMRDATA;
   endtask

   task automatic read_reg(input int r, output logic [31:0] v);
      ins_t in = mk(r, 1, 32'h200 + 32'(r), 8);
      in.lmwr = 1;
      exec(in);
      host_rd(10'(32'h200 + 32'(r)), v);
   endtask

   initial begin
      ins_t        in;
      logic [31:0] v, newv, expv;

      iRST = 1; iDEC_VALID = 0; iDEC_RA = 0; iDEC_RB = 0; iDEC_BSEL = 0;
      iDEC_IMM = 0; iGMEMDATA = 0; iEX_VALID = 0; iEX_OP = 0; iEX_COND = 0;
      iEX_SETS = 0; iEX_LMWR = 0; iEX_MC = 0; iWB_VALID = 0; iWB_RD = 0;
      iWB_REGWR = 0; iWB_LMRD = 0; iWB_MC = 0; iLMEMSEL = 0; iLMEMWREN = 0;
      iLMEMADDR = 0; iLMEMWDATA = 0;
      repeat (3) @(posedge iACLK);
      #1 iRST = 0;
      check("rst_busy", 32'(oBUSY), 32'h0);
      check("rst_sreg", 32'(oSREG), 32'h0);
      check("rst_lmem", oLMEMRDATA, 32'h0);

      for (int i = 0; i < 16; i++) host_wr(10'(i), $urandom);
      for (int r = 1; r < 8; r++) begin
         in = mk(1, 1, (r == 1) ? 32'hFFFF_FFFF :
                       (r == 4) ? 32'h0001_2345 : $urandom, 8);
         in.rd = r; in.regwr = 1;
         exec(in);
      end

      in = mk(1, 1, 32'h1, 0);
      in.sets = 1; in.rd = 2; in.regwr = 1;
      exec(in);
      check("add_sreg", 32'(oSREG), 32'h5);

      host_wr(10'h020, 32'h1111_2222);
      in = mk(1, 1, 32'h20, 8);
      in.cond = 2; in.lmwr = 1; in.regwr = 1; in.rd = 6;
      exec(in);
      host_rd(10'h020, v);
      check("ne_nowrite", v, 32'h1111_2222);
      read_reg(6, v);
      check("ne_noreg", v, rf_m[6]);

      in = mk(2, 1, 32'h0, 1);
      in.rd = 3; in.regwr = 1;
      exec(in);
      read_reg(3, v);
      check("adc", v, 32'h1);

      in = mk(4, 1, 32'h100, 0);
      in.mc = 1; in.sets = 1; in.rd = 5; in.regwr = 1;
      exec(in);
      read_reg(5, v);
      check("mul", v, 32'h0123_4500);

      in = mk(1, 1, 32'h5A, 8);
      in.rd = 7; in.regwr = 1;
      exec(in);
      iDEC_VALID = 1; iDEC_RA = 5'd7; iDEC_BSEL = 2'd1; iDEC_IMM = 32'h7FF;
      @(posedge iACLK); #1;
      iDEC_VALID = 0;
      iEX_VALID = 1; iEX_OP = 4'd8; iEX_COND = 4'd0; iEX_LMWR = 1;
      iLMEMSEL = 1; iLMEMWREN = 1; iLMEMADDR = 10'h3FF;
      iLMEMWDATA = 32'hA5;
      @(posedge iACLK); #1;
      iEX_VALID = 0; iEX_LMWR = 0; iLMEMSEL = 0; iLMEMWREN = 0;
      mem_m[10'h3FF] = 32'h5A;
      host_rd(10'h3FF, v);
      check("collide", v, 32'h5A);

      // Producer writes back while the consumer decodes r3
      newv = rf_m[3] ^ 32'h0F0F_0001;
      iDEC_VALID = 1; iDEC_RA = 5'd1; iDEC_BSEL = 2'd1; iDEC_IMM = newv;
      @(posedge iACLK); #1;
      iDEC_VALID = 0;
      iEX_VALID = 1; iEX_OP = 4'd8; iEX_COND = 4'd0;
      @(posedge iACLK); #1;
      iEX_VALID = 0;
      iWB_VALID = 1; iWB_RD = 5'd3; iWB_REGWR = 1;
      iDEC_VALID = 1; iDEC_RA = 5'd3; iDEC_BSEL = 2'd1; iDEC_IMM = 32'h40;
      @(posedge iACLK); #1;
      iWB_VALID = 0; iWB_REGWR = 0; iDEC_VALID = 0;
      iEX_VALID = 1; iEX_OP = 4'd8; iEX_LMWR = 1;
      @(posedge iACLK); #1;
      iEX_VALID = 0; iEX_LMWR = 0;
`ifdef GPPCU_LANE_FWD_EN
      expv = newv;
`else
      expv = rf_m[3];
`endif
      mem_m[10'h040] = expv;
      rf_m[3] = newv;
      host_rd(10'h040, v);
      check("fwd_r3", v, expv);

      in = mk(1, 1, 32'h8000_0000, 8);
      in.sets = 1;
      exec(in);
      host_rd(10'h3FF, v);
      check("pre_rst_lmem", v, mem_m[10'h3FF]);
      iDEC_VALID = 1; iDEC_RA = 5'd4; iDEC_BSEL = 2'd1; iDEC_IMM = 32'h3;
      @(posedge iACLK); #1;
      iDEC_VALID = 0;
      iEX_VALID = 1; iEX_OP = 4'd0; iEX_COND = 4'd0; iEX_MC = 1;
      repeat (5) @(posedge iACLK);
      #1;
      check("mid_mul_busy", 32'(oBUSY), 32'h1);
      iRST = 1; iEX_VALID = 0; iEX_MC = 0;
      @(posedge iACLK); #1;
      iRST = 0;
      sreg_m = 4'h0;
      check("mid_rst_busy", 32'(oBUSY), 32'h0);
      check("mid_rst_sreg", 32'(oSREG), 32'h0);
      check("mid_rst_lmem", oLMEMRDATA, 32'h0);

      for (int i = 0; i < 80; i++) exec(rand_ins());

      for (int r = 1; r < 8; r++) begin
         read_reg(r, v);
         check($sformatf("r%0d", r), v, rf_m[r]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
